// File: rtl/dot_product.sv
// dot_product: two-stage signed N-element dot product, result wrapped to WIDTH bits
module dot_product #(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] a [N],
  input  logic signed [WIDTH-1:0] b [N],
  output logic signed [WIDTH-1:0] out,
  output logic                    out_valid
);
  localparam int L  = $clog2(N);
  localparam int P  = 1 << L;
  localparam int PW = 2 * WIDTH;
  localparam int SW = PW + L;
  logic signed [PW-1:0] p [P];
  logic signed [SW-1:0] t [P];
  logic                 v1;
  // p is padded to a power of two; entries past N stay zero and act as tree leaves
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < P; i++) p[i] <= '0;
      v1        <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      v1        <= in_valid;
      out_valid <= v1;
      if (in_valid)
        for (int i = 0; i < N; i++) p[i] <= PW'(a[i]) * PW'(b[i]);
      if (v1) out <= WIDTH'(t[0]);
    end
  end
  always_comb begin
    for (int i = 0; i < P; i++) t[i] = SW'(p[i]);
    for (int s = P / 2; s > 0; s = s / 2)
      for (int i = 0; i < s; i++) t[i] = t[2*i] + t[2*i+1];
  end
endmodule

// File: tb/tb_dot_product.sv
// tb_dot_product: directed and random checks of dot_product against an arithmetic model
module tb_dot_product;
  localparam int W = 8;
  localparam int N = 4;
  typedef logic signed [W-1:0] vec_t [N];
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0;
  vec_t a = '{default: '0};
  vec_t b = '{default: '0};
  logic signed [W-1:0] out;
  logic out_valid;
  int n_chk = 0;
  int n_fail = 0;
  logic signed [W-1:0] exp_out = '0;
  logic signed [W-1:0] pval = '0;
  logic exp_v = 1'b0;
  logic pv = 1'b0;

  dot_product #(.WIDTH(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a), .b(b), .out(out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic signed [W-1:0] ref_dot(input vec_t x, input vec_t y);
    int s = 0;
    for (int i = 0; i < N; i++) s += int'(x[i]) * int'(y[i]);
    return W'(s);
  endfunction

  task automatic chk(input string tag);
    n_chk++;
    assert (out_valid === exp_v) else begin
      n_fail++;
      $error("FAIL %s out_valid got %b want %b", tag, out_valid, exp_v);
    end
    n_chk++;
    assert (out === exp_out) else begin
      n_fail++;
      $error("FAIL %s out got %h want %h", tag, out, exp_out);
    end
  endtask

  task automatic chk_const(input string tag, input logic signed [W-1:0] want);
    n_chk++;
    assert (out_valid === 1'b1 && out === want) else begin
      n_fail++;
      $error("FAIL %s out/valid got %h/%b want %h/1", tag, out, out_valid, want);
    end
  endtask

  // Drive one beat, clock it, advance the model, then check just after the edge
  task automatic beat(input logic v, input vec_t x, input vec_t y, input string tag);
    a = x;
    b = y;
    in_valid = v;
    @(posedge clk);
    if (rst_n) begin
      exp_v = pv;
      if (pv) exp_out = pval;
      pv = v;
      pval = ref_dot(x, y);
    end
    #1;
    chk(tag);
  endtask

  function automatic logic signed [W-1:0] pick();
    case ($urandom_range(0, 4))
      0: return 8'sh80;
      1: return 8'sh7F;
      2: return 8'shFF;
      3: return 8'sh00;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    vec_t z, pa, pb, m1, mx, mn, un, rx, ry;
    z  = '{default: 8'sh00};
    pa = '{8'sd3, 8'sd1, 8'sd1, 8'sd2};
    pb = '{8'sd3, 8'sd1, 8'sd2, 8'sd1};
    m1 = '{default: 8'shFF};
    mx = '{default: 8'sh7F};
    mn = '{8'sh80, 8'sh00, 8'sh00, 8'sh00};
    un = '{8'sh01, 8'sh00, 8'sh00, 8'sh00};
    #1 rst_n = 1'b0;
    in_valid = 1'b1;
    a = pa;
    b = pb;
    repeat (2) @(posedge clk);
    #1 chk("reset");
    #2 rst_n = 1'b1;
    beat(1'b1, z, z, "zero_in");
    beat(1'b1, pa, pb, "zero_out");
    chk_const("zero", 8'h00);
    beat(1'b1, m1, m1, "pos_out");
    chk_const("pos", 8'h0E);
    beat(1'b1, mx, mx, "negneg_out");
    chk_const("negneg", 8'h04);
    beat(1'b1, mn, un, "wrap_out");
    chk_const("wrap", 8'h04);
    beat(1'b0, z, z, "mixed_out");
    chk_const("mixed", 8'h80);
    beat(1'b0, pa, pb, "bubble");
    n_chk++;
    assert (out_valid === 1'b0 && out === 8'sh80) else begin
      n_fail++;
      $error("FAIL bubble_hold out/valid got %h/%b want 80/0", out, out_valid);
    end
    beat(1'b1, pa, pb, "pre_rst");
    beat(1'b1, mx, mx, "pre_rst2");
    #2 rst_n = 1'b0;
    exp_v = 1'b0;
    exp_out = '0;
    pv = 1'b0;
    #1 chk("async_rst");
    beat(1'b1, m1, m1, "in_rst");
    #2 rst_n = 1'b1;
    beat(1'b0, z, z, "post_rst");
    beat(1'b0, z, z, "no_stale");
    beat(1'b1, pa, pb, "first_after");
    beat(1'b0, z, z, "first_after_out");
    chk_const("first_after", 8'h0E);
    repeat (80) begin
      for (int i = 0; i < N; i++) begin
        rx[i] = pick();
        ry[i] = pick();
      end
      beat($urandom_range(0, 3) != 0, rx, ry, "random");
    end
    beat(1'b0, z, z, "drain1");
    beat(1'b0, z, z, "drain2");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
